// File: rtl/arp_cache_pkg.sv
// Shared types and constants for the ARP cache: lookup FSM encoding, table entry layout,
// and the helpers that turn clock frequency into second / timeout cycle counts.
package arp_cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_REQ,
        ST_WAIT,
        ST_DONE_HIT,
        ST_DONE_FAIL
    } fsm_state_e;

    localparam int unsigned DEFAULT_CLK_FREQ_HZ    = 125000000;
    localparam int unsigned DEFAULT_REQ_TIMEOUT_MS = 100;

    typedef struct packed {
        logic        valid;
        logic [31:0] ip;
        logic [47:0] mac;
        logic [7:0]  age;
    } entry_t;

    function automatic logic [31:0] second_cycles(input int unsigned clk_hz);
        logic [31:0] c;
        c = 32'(clk_hz);
        if (c == 32'd0) c = 32'd1;
        return c;
    endfunction

    // Slow test clocks can round the timeout to zero; one cycle is the floor.
    function automatic logic [31:0] timeout_cycles(input int unsigned clk_hz, input int unsigned ms);
        logic [31:0] c;
        c = 32'(clk_hz / 1000 * ms);
        if (c == 32'd0) c = 32'd1;
        return c;
    endfunction

endpackage

// File: rtl/arp_cache_table_age_tick.sv
// One-second prescaler: raises tick for a single cycle every CLK_FREQ_HZ cycles.
module arp_age_tick
    import arp_cache_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ
) (
    input  logic tx_clk,
    input  logic reset_n,
    output logic tick
);

    localparam logic [31:0] LAST = second_cycles(CLK_FREQ_HZ) - 32'd1;

    logic [31:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick ? 32'd0 : cnt_q + 32'd1;
    end

    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= 32'd0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/arp_cache_table.sv
// ARP MAC cache: DEPTH flop entries with ageing and oldest-first replacement, plus a lookup
// FSM that scans the table one entry per cycle and issues timed ARP requests on a miss.
module arp_cache_table
    import arp_cache_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int CLK_FREQ_HZ    = 125000000,
    parameter int ARP_AGE        = 60,
    parameter int REQ_TIMEOUT_MS = 100,
    parameter int REQ_RETRY      = 3
) (
    input  logic                     tx_clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     w_en,
    input  logic [47:0]              w_mac_address,
    input  logic [31:0]              w_ip_address,
    input  logic                     r_en,
    input  logic [31:0]              r_ip_addr,
    output logic                     r_busy,
    output logic                     r_e,
    output logic                     r_hit,
    output logic [47:0]              r_mac_addr,
    output logic                     request_send_en,
    output logic [31:0]              request_ip_addr,
    output logic [$clog2(DEPTH):0]   entry_count,
    output fsm_state_e               dbg_state
);

    localparam int          IW  = $clog2(DEPTH);
    localparam int          CW  = IW + 1;
    localparam logic [31:0] TMO = timeout_cycles(CLK_FREQ_HZ, REQ_TIMEOUT_MS);

    entry_t        tbl_q [DEPTH];
    entry_t        tbl_d [DEPTH];
    logic [IW-1:0] rep_ptr_q, rep_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_hit, wr_free;
    logic [IW-1:0] wr_hit_idx, wr_free_idx, wr_idx;
    logic          tick;

    fsm_state_e    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [31:0]   ip_q, ip_d;
    logic [47:0]   mac_q, mac_d;
    logic [31:0]   req_ip_q, req_ip_d;
    logic          req_pulse_q, req_pulse_d;
    logic [3:0]    retry_q, retry_d;
    logic [31:0]   tmo_q, tmo_d;
    logic          w_match;

    arp_age_tick #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_age_tick (
        .tx_clk  (tx_clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    // Descending scan so the lowest matching / free index wins.
    always_comb begin
        wr_hit      = 1'b0;
        wr_free     = 1'b0;
        wr_hit_idx  = '0;
        wr_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (tbl_q[i].valid && tbl_q[i].ip == w_ip_address) begin
                wr_hit     = 1'b1;
                wr_hit_idx = IW'(i);
            end
            if (!tbl_q[i].valid) begin
                wr_free     = 1'b1;
                wr_free_idx = IW'(i);
            end
        end
        wr_idx = wr_hit ? wr_hit_idx : (wr_free ? wr_free_idx : rep_ptr_q);
    end

    // Ageing first, then the write overrides its slot, then flush overrides everything.
    always_comb begin
        rep_ptr_d = rep_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            tbl_d[i] = tbl_q[i];
            if (tick && tbl_q[i].valid) begin
                if (tbl_q[i].age >= 8'(ARP_AGE - 1)) begin
                    tbl_d[i].valid = 1'b0;
                    tbl_d[i].age   = 8'd0;
                end else begin
                    tbl_d[i].age = tbl_q[i].age + 8'd1;
                end
            end
        end
        if (w_en) begin
            tbl_d[wr_idx] = '{valid: 1'b1, ip: w_ip_address, mac: w_mac_address, age: 8'd0};
            if (!wr_hit && !wr_free) rep_ptr_d = rep_ptr_q + IW'(1);
        end
        if (flush) begin
            rep_ptr_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_d[i].valid = 1'b0;
                tbl_d[i].age   = 8'd0;
            end
        end
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) cnt_d = cnt_d + CW'(tbl_q[i].valid);
    end

    // r_en is a request qualified by r_busy=0 (ready); r_e is a one-cycle completion strobe
    // with r_hit qualifying it. A pending lookup cannot be cancelled except by reset.
    assign w_match = w_en && !flush && (w_ip_address == ip_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ip_d        = ip_q;
        mac_d       = mac_q;
        req_ip_d    = req_ip_q;
        req_pulse_d = 1'b0;
        retry_d     = retry_q;
        tmo_d       = tmo_q;
        case (state_q)
            ST_IDLE, ST_DONE_HIT, ST_DONE_FAIL: begin
                state_d = ST_IDLE;
                if (r_en) begin
                    ip_d    = r_ip_addr;
                    idx_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_match) begin
                    mac_d   = w_mac_address;
                    state_d = ST_DONE_HIT;
                end else if (tbl_q[idx_q].valid && tbl_q[idx_q].ip == ip_q) begin
                    mac_d   = tbl_q[idx_q].mac;
                    state_d = ST_DONE_HIT;
                end else if (idx_q == IW'(DEPTH - 1)) begin
                    retry_d = 4'd0;
                    state_d = ST_REQ;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_REQ: begin
                req_pulse_d = 1'b1;
                req_ip_d    = ip_q;
                retry_d     = retry_q + 4'd1;
                tmo_d       = TMO;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                // WAIT spans TMO cycles, so requests are spaced TMO+1 cycles apart.
                if (w_match) begin
                    mac_d   = w_mac_address;
                    state_d = ST_DONE_HIT;
                end else if (tmo_q <= 32'd1) begin
                    state_d = (retry_q < 4'(REQ_RETRY)) ? ST_REQ : ST_DONE_FAIL;
                end else begin
                    tmo_d = tmo_q - 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
            rep_ptr_q   <= '0;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            ip_q        <= '0;
            mac_q       <= '0;
            req_ip_q    <= '0;
            req_pulse_q <= 1'b0;
            retry_q     <= '0;
            tmo_q       <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= tbl_d[i];
            rep_ptr_q   <= rep_ptr_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            ip_q        <= ip_d;
            mac_q       <= mac_d;
            req_ip_q    <= req_ip_d;
            req_pulse_q <= req_pulse_d;
            retry_q     <= retry_d;
            tmo_q       <= tmo_d;
        end
    end

    assign r_busy          = (state_q == ST_SCAN) || (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign r_e             = (state_q == ST_DONE_HIT) || (state_q == ST_DONE_FAIL);
    assign r_hit           = (state_q == ST_DONE_HIT);
    assign r_mac_addr      = mac_q;
    assign request_send_en = req_pulse_q;
    assign request_ip_addr = req_ip_q;
    assign entry_count     = cnt_q;
    assign dbg_state       = state_q;

endmodule
